jzjpcc_immediateunit: RTL and testbench
=======================================

# jzjpcc_immediateUnit

Parametrised, registered immediate-generation stage between fetch/decode and execute. It accepts one beat of LANES instructions per cycle over a valid/ready handshake. Per lane it decodes the immediate type from the opcode and emits the sign- or zero-extended XLEN-bit immediate plus a type tag one cycle later. An optional 2-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `XLEN`, default 32: immediate output width per lane; legal values 32, 64.
- `LANES`, default 1: instructions per beat; legal values 1–4.
- `SKID`, default 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `in_instruction`  in  LANES*30  lane n is bits [30n+29:30n], holding instruction bits [31:2].
- `flush`  in  1  synchronous discard of all held beats and of any beat offered this cycle.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_immediate`  out  LANES*XLEN  lane n is bits [XLEN*n+XLEN-1:XLEN*n].
- `out_immType`  out  LANES*3  per-lane tag: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.

## Operation
- Per-lane decode uses opcode bits [6:2]:
  - I: LOAD 00000, MISC_MEM 00011, OP_IMM 00100, JALR 11001, and OP_IMM_32 00110 (XLEN=64 only).
  - U: AUIPC 00101, LUI 01101.
  - S: STORE 01000.
  - B: BRANCH 11000.
  - J: JAL 11011.
  - SYSTEM 11100: bit 14 = 1 gives Z; bit 14 = 0 gives I.
- Any other opcode, including OP_IMM_32 when XLEN=32, gives tag 0 and immediate 0. The output is never X.
- Field layouts (bit 31 = s):
  - I: s, [30:20].
  - S: s, [30:25], [11:7].
  - B: s, [7], [30:25], [11:8], 0.
  - U: s, [30:12], twelve 0s.
  - J: s, [19:12], [20], [30:21], 0.
  - Z: [19:15] zero-extended.
- Extension: I/S/B/U/J are sign-extended from s to XLEN, so U is sign-extended above bit 31 when XLEN=64. Z is zero-extended.
- A beat is accepted when `in_valid && in_ready && !flush`. It is delivered when `out_valid && out_ready`. All lanes move together.
- SKID=1 state machine (reset state EMPTY):
  - EMPTY (out_valid 0, in_ready 1): accept → ONE.
  - ONE (out_valid 1, in_ready 1):
    - accept and deliver → ONE, main register reloaded;
    - accept without deliver → TWO, beat into skid register;
    - deliver only → EMPTY;
    - neither → hold.
  - TWO (out_valid 1, in_ready 0): deliver → ONE, skid moves to main. Otherwise hold.
  - `in_ready` is a flop: high unless the next state is TWO.
- SKID=0: one main register.
  - `in_ready = out_ready || !out_valid`.
  - Accept sets out_valid. Deliver without accept clears it.
- Output data comes from the main register. It is stable while `out_valid && !out_ready`.
- While out_valid is 0, data holds its last value (0 after reset).
- `flush` has priority over every other event. Next state is EMPTY/invalid, any simultaneous input beat is dropped, and data registers are unchanged.
- Reset values: out_valid 0, in_ready 1, out_immediate 0, out_immType 0, state EMPTY.

## Timing
- Latency: beat accepted at edge k appears on outputs after edge k, i.e. valid in cycle k+1.
- Throughput is 1 beat/cycle in both SKID modes while out_ready stays high.
- SKID=1: in_ready falls the cycle after the second unconsumed beat is accepted. It rises the cycle after the first delivery from TWO.
- No combinational path from `in_*` or `out_ready` to `out_*` in either mode.
- No combinational path from `out_ready` to `in_ready` when SKID=1.
- Asserting reset in any state forces the reset values immediately, without waiting for a clock edge. Deassertion takes effect at the next edge.
- Beats are never lost, duplicated, or reordered except by flush or reset.

## Test plan
- Reset: assert reset mid-run in state TWO → out_valid 0, in_ready 1, out_immediate 0, out_immType 0 immediately, before any clock edge.
- Decode, XLEN=32, LANES=1, out_ready 1, one instruction per beat → next cycle:
  - 0xFFF00093 → tag 1, 0xFFFFFFFF.
  - 0xFE112E23 → tag 2, 0xFFFFFFFC.
  - 0x123452B7 → tag 4, 0x12345000.
  - 0xFF9FF06F → tag 5, 0xFFFFFFF8.
  - 0x300FD073 → tag 6, 0x0000001F.
- Backpressure, SKID=1: out_ready 0, push A=0x00500093 and B=0x00A00093 → in_ready 0 after B; outputs hold A (5). Raise out_ready → A (5) then B (10) delivered on consecutive cycles; in_ready back to 1.
- Flush in TWO with in_valid 1 → next cycle out_valid 0, in_ready 1. The offered beat never appears.
- XLEN=64, LANES=2: lane0 0x800000B7, lane1 0x0000000B → lane0 tag 4, 0xFFFFFFFF80000000; lane1 tag 0, 0x0000000000000000.
- SKID=0 streaming: out_ready toggled 1,0,1,0 over 8 beats → every beat delivered exactly once in order. in_ready equals out_ready whenever out_valid is 1.

Source files
------------

// File: rtl/jzjpcc_immediateunit.sv
// ---------------------------------------------------------------------------
// jzjpcc_immediateunit
//   Registered immediate-generation stage. Each accepted beat carries LANES
//   instructions (bits [31:2] only). Every lane is decoded into an XLEN-bit
//   immediate and a 3-bit type tag. The result leaves on the next cycle over a
//   valid/ready handshake.
//
//   Parameters
//     XLEN   32 or 64        immediate width per lane
//     LANES  1..4            instructions per beat
//     SKID   1 / 0           2-entry skid buffer with registered in_ready /
//                            single register with combinational in_ready
//
//   Ports
//     clock, reset           rising-edge clock, async active-high reset
//     in_valid/in_ready      upstream handshake
//     in_instruction         LANES x 30 bits, lane n at [30n+29:30n]
//     flush                  synchronous discard of held and offered beats
//     out_valid/out_ready    downstream handshake
//     out_immediate          LANES x XLEN bits, lane n at [XLEN*n+XLEN-1:XLEN*n]
//     out_immType            LANES x 3 bits: 0 none,1 I,2 S,3 B,4 U,5 J,6 Z
// ---------------------------------------------------------------------------
module jzjpcc_immediateunit #(
    parameter int XLEN  = 32,
    parameter int LANES = 1,
    parameter int SKID  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*30-1:0]     in_instruction,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*XLEN-1:0]   out_immediate,
    output logic [LANES*3-1:0]      out_immType
);

    localparam logic [2:0] TAG_NONE = 3'd0;
    localparam logic [2:0] TAG_I    = 3'd1;
    localparam logic [2:0] TAG_S    = 3'd2;
    localparam logic [2:0] TAG_B    = 3'd3;
    localparam logic [2:0] TAG_U    = 3'd4;
    localparam logic [2:0] TAG_J    = 3'd5;
    localparam logic [2:0] TAG_Z    = 3'd6;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Decode one lane. Result is {tag, immediate}.
    function automatic logic [XLEN+2:0] decode_lane(input logic [29:0] ins);
        logic [31:0]     f;
        logic [31:0]     v32;
        logic [2:0]      tag;
        logic            sext;
        logic [XLEN-1:0] imm;
        // Bits [1:0] are not carried; pad them so field indices match the ISA.
        f    = {ins, 2'b11};
        v32  = 32'd0;
        tag  = TAG_NONE;
        sext = 1'b0;
        case (f[6:2])
            5'b00000, 5'b00011, 5'b00100, 5'b11001: tag = TAG_I;
            5'b00110: begin
                // OP_IMM_32 only exists on RV64.
                if (XLEN == 64) begin
                    tag = TAG_I;
                end else begin
                    tag = TAG_NONE;
                end
            end
            5'b00101, 5'b01101: tag = TAG_U;
            5'b01000:           tag = TAG_S;
            5'b11000:           tag = TAG_B;
            5'b11011:           tag = TAG_J;
            5'b11100: begin
                if (f[14]) begin
                    tag = TAG_Z;
                end else begin
                    tag = TAG_I;
                end
            end
            default:            tag = TAG_NONE;
        endcase
        case (tag)
            TAG_I: begin
                v32  = {{21{f[31]}}, f[30:20]};
                sext = f[31];
            end
            TAG_S: begin
                v32  = {{21{f[31]}}, f[30:25], f[11:7]};
                sext = f[31];
            end
            TAG_B: begin
                v32  = {{20{f[31]}}, f[7], f[30:25], f[11:8], 1'b0};
                sext = f[31];
            end
            TAG_U: begin
                v32  = {f[31], f[30:12], 12'd0};
                sext = f[31];
            end
            TAG_J: begin
                v32  = {{12{f[31]}}, f[19:12], f[20], f[30:21], 1'b0};
                sext = f[31];
            end
            TAG_Z: begin
                v32  = {27'd0, f[19:15]};
                sext = 1'b0;
            end
            default: begin
                v32  = 32'd0;
                sext = 1'b0;
            end
        endcase
        imm        = '0;
        imm[31:0]  = v32;
        // Extend above bit 31 (no iterations when XLEN is 32).
        for (int b = 32; b < XLEN; b++) begin
            imm[b] = sext;
        end
        return {tag, imm};
    endfunction

    logic [LANES*XLEN-1:0] dec_imm_s;
    logic [LANES*3-1:0]    dec_tag_s;
    logic [XLEN+2:0]       lane_s;

    state_e                state_q,     state_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [LANES*XLEN-1:0] main_imm_q,  main_imm_d;
    logic [LANES*3-1:0]    main_tag_q,  main_tag_d;
    logic [LANES*XLEN-1:0] skid_imm_q,  skid_imm_d;
    logic [LANES*3-1:0]    skid_tag_q,  skid_tag_d;

    logic                  in_ready_s;
    logic                  accept_s;
    logic                  deliver_s;

    // Per-lane immediate decode of the offered beat.
    always_comb begin
        dec_imm_s = '0;
        dec_tag_s = '0;
        lane_s    = '0;
        for (int n = 0; n < LANES; n++) begin
            lane_s                   = decode_lane(in_instruction[30*n +: 30]);
            dec_imm_s[XLEN*n +: XLEN] = lane_s[XLEN-1:0];
            dec_tag_s[3*n +: 3]       = lane_s[XLEN+2:XLEN];
        end
    end

    // Handshake qualifiers; in_ready is a flop only in skid mode.
    always_comb begin
        if (SKID != 0) begin
            in_ready_s = in_ready_q;
        end else begin
            in_ready_s = out_ready || !out_valid_q;
        end
        accept_s  = in_valid && in_ready_s && !flush;
        deliver_s = out_valid_q && out_ready;
    end

    // Next-state and data-register selection; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (SKID != 0) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d    = ST_ONE;
                        main_imm_d = dec_imm_s;
                        main_tag_d = dec_tag_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && deliver_s) begin
                        state_d    = ST_ONE;
                        main_imm_d = dec_imm_s;
                        main_tag_d = dec_tag_s;
                    end else if (accept_s) begin
                        // Downstream stalled: park the new beat behind the main one.
                        state_d    = ST_TWO;
                        skid_imm_d = dec_imm_s;
                        skid_tag_d = dec_tag_s;
                    end else if (deliver_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (deliver_s) begin
                        state_d    = ST_ONE;
                        main_imm_d = skid_imm_q;
                        main_tag_d = skid_tag_q;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end else begin
            // Single-register mode uses only EMPTY/ONE.
            if (accept_s) begin
                state_d    = ST_ONE;
                main_imm_d = dec_imm_s;
                main_tag_d = dec_tag_s;
            end else if (deliver_s) begin
                state_d = ST_EMPTY;
            end else begin
                state_d = state_q;
            end
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    // State and data registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_imm_q  <= '0;
            main_tag_q  <= '0;
            skid_imm_q  <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_imm_q  <= main_imm_d;
            main_tag_q  <= main_tag_d;
            skid_imm_q  <= skid_imm_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_q;
    assign out_immediate = main_imm_q;
    assign out_immType   = main_tag_q;

endmodule

// File: tb/tb_jzjpcc_immediateunit.sv
module tb_jzjpcc_immediateunit;

    logic clock;
    logic reset;

    // Default instance: XLEN=32, LANES=1, SKID=1
    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [29:0] a_instr;
    logic [31:0] a_imm;
    logic [2:0]  a_tag;

    // Wide instance: XLEN=64, LANES=2, SKID=1
    logic         w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready;
    logic [59:0]  w_instr;
    logic [127:0] w_imm;
    logic [5:0]   w_tag;

    // Single-register instance: XLEN=32, LANES=1, SKID=0
    logic        z_in_valid, z_in_ready, z_flush, z_out_valid, z_out_ready;
    logic [29:0] z_instr;
    logic [31:0] z_imm;
    logic [2:0]  z_tag;

    int vectors;
    int miscompares;

    jzjpcc_immediateunit dut (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instruction(a_instr),
        .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_immediate(a_imm), .out_immType(a_tag)
    );

    jzjpcc_immediateunit #(.XLEN(64), .LANES(2), .SKID(1)) dut64 (
        .clock(clock), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instruction(w_instr),
        .flush(w_flush), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_immediate(w_imm), .out_immType(w_tag)
    );

    jzjpcc_immediateunit #(.XLEN(32), .LANES(1), .SKID(0)) dut0 (
        .clock(clock), .reset(reset),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_instruction(z_instr),
        .flush(z_flush), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_immediate(z_imm), .out_immType(z_tag)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [29:0] upper30(input logic [31:0] w);
        return w[31:2];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", a_out_valid); end
        vectors++;
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", a_in_ready); end
        vectors++;
        if (a_imm !== 32'd0 || a_tag !== 3'd0) begin miscompares++; $display("FAIL reset_data got %h/%0d want 0/0", a_imm, a_tag); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_decode();
        logic [31:0] words [9];
        logic [2:0]  tags  [9];
        logic [31:0] imms  [9];
        words[0] = 32'hFFF00093; tags[0] = 3'd1; imms[0] = 32'hFFFFFFFF;
        words[1] = 32'hFE112E23; tags[1] = 3'd2; imms[1] = 32'hFFFFFFFC;
        words[2] = 32'h123452B7; tags[2] = 3'd4; imms[2] = 32'h12345000;
        words[3] = 32'hFF9FF06F; tags[3] = 3'd5; imms[3] = 32'hFFFFFFF8;
        words[4] = 32'h300FD073; tags[4] = 3'd6; imms[4] = 32'h0000001F;
        words[5] = 32'hFE000EE3; tags[5] = 3'd3; imms[5] = 32'hFFFFFFFC;
        words[6] = 32'h0010009B; tags[6] = 3'd0; imms[6] = 32'h00000000;
        words[7] = 32'h30001073; tags[7] = 3'd1; imms[7] = 32'h00000300;
        words[8] = 32'h80008067; tags[8] = 3'd1; imms[8] = 32'hFFFFF800;
        a_out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a_in_valid = 1'b1;
            a_instr    = upper30(words[i]);
            step();
            vectors++;
            if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL decode_valid[%0d] got %b want 1", i, a_out_valid); end
            vectors++;
            if (a_tag !== tags[i]) begin miscompares++; $display("FAIL decode_tag[%0d] got %0d want %0d", i, a_tag, tags[i]); end
            vectors++;
            if (a_imm !== imms[i]) begin miscompares++; $display("FAIL decode_imm[%0d] got %h want %h", i, a_imm, imms[i]); end
        end
        a_in_valid = 1'b0;
        step();
        vectors++;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL decode_drain got %b want 0", a_out_valid); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_instr     = upper30(32'h00500093);
        step();
        vectors++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_one got rdy %b vld %b want 1 1", a_in_ready, a_out_valid); end
        a_instr = upper30(32'h00A00093);
        step();
        a_in_valid = 1'b0;
        vectors++;
        if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full got %b want 0", a_in_ready); end
        step();
        vectors++;
        if (a_imm !== 32'd5 || a_out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold got %h vld %b want 5 1", a_imm, a_out_valid); end
        a_out_ready = 1'b1;
        #1;
        vectors++;
        if (a_imm !== 32'd5) begin miscompares++; $display("FAIL bp_first got %h want 5", a_imm); end
        step();
        vectors++;
        if (a_imm !== 32'd10 || a_out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_second got %h vld %b want a 1", a_imm, a_out_valid); end
        vectors++;
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back got %b want 1", a_in_ready); end
        step();
        vectors++;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %b want 0", a_out_valid); end
    endtask

    task automatic fill_two(input logic [31:0] first, input logic [31:0] second);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_instr     = upper30(first);
        step();
        a_instr = upper30(second);
        step();
        a_in_valid = 1'b0;
        vectors++;
        if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_two got rdy %b want 0", a_in_ready); end
    endtask

    task automatic test_flush();
        fill_two(32'h00300093, 32'h00400093);
        a_flush    = 1'b1;
        a_in_valid = 1'b1;
        a_instr    = upper30(32'h00700093);
        step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_state got vld %b rdy %b want 0 1", a_out_valid, a_in_ready); end
        vectors++;
        if (a_imm !== 32'd3) begin miscompares++; $display("FAIL flush_data_kept got %h want 3", a_imm); end
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_beat[%0d] got %b want 0", i, a_out_valid); end
        end
    endtask

    task automatic test_reset_in_two();
        fill_two(32'h00600093, 32'h00800093);
        reset = 1'b1;
        #1;
        vectors++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL async_reset_ctl got vld %b rdy %b want 0 1", a_out_valid, a_in_ready); end
        vectors++;
        if (a_imm !== 32'd0 || a_tag !== 3'd0) begin miscompares++; $display("FAIL async_reset_data got %h/%0d want 0/0", a_imm, a_tag); end
        step();
        reset       = 1'b0;
        a_out_ready = 1'b1;
        step();
        vectors++;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_release got %b want 0", a_out_valid); end
    endtask

    task automatic test_xlen64();
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_instr     = {upper30(32'h0000000B), upper30(32'h800000B7)};
        step();
        vectors++;
        if (w_out_valid !== 1'b1 || w_tag !== {3'd0, 3'd4}) begin miscompares++; $display("FAIL x64_tags0 got vld %b tag %h want 1 04", w_out_valid, w_tag); end
        vectors++;
        if (w_imm !== {64'h0, 64'hFFFFFFFF80000000}) begin miscompares++; $display("FAIL x64_imm0 got %h want 0000000000000000ffffffff80000000", w_imm); end
        w_instr = {upper30(32'h0010009B), upper30(32'hFFF0009B)};
        step();
        w_in_valid = 1'b0;
        vectors++;
        if (w_tag !== {3'd1, 3'd1}) begin miscompares++; $display("FAIL x64_tags1 got %h want 09", w_tag); end
        vectors++;
        if (w_imm !== {64'h1, 64'hFFFFFFFFFFFFFFFF}) begin miscompares++; $display("FAIL x64_imm1 got %h want 0000000000000001ffffffffffffffff", w_imm); end
        step();
    endtask

    task automatic test_skid0_stream();
        int  sent;
        int  got;
        logic acc;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            z_out_ready = (cyc % 2 == 0);
            z_in_valid  = (sent < 8);
            z_instr     = upper30(32'h00000093 | (32'(sent + 1) << 20));
            #1;
            if (z_out_valid) begin
                vectors++;
                if (z_in_ready !== z_out_ready) begin miscompares++; $display("FAIL s0_ready[%0d] got %b want %b", cyc, z_in_ready, z_out_ready); end
            end
            if (z_out_valid && z_out_ready) begin
                vectors++;
                if (z_imm !== 32'(got + 1) || z_tag !== 3'd1) begin miscompares++; $display("FAIL s0_order[%0d] got %h/%0d want %h/1", got, z_imm, z_tag, got + 1); end
                got++;
            end
            acc = z_in_valid && z_in_ready;
            @(posedge clock);
            if (acc) sent++;
            #1;
        end
        z_in_valid = 1'b0;
        vectors++;
        if (got != 8) begin miscompares++; $display("FAIL s0_count got %0d want 8", got); end
        step();
        vectors++;
        if (z_out_valid !== 1'b0) begin miscompares++; $display("FAIL s0_no_dup got %b want 0", z_out_valid); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0; a_instr = '0;
        w_in_valid = 1'b0; w_flush = 1'b0; w_out_ready = 1'b0; w_instr = '0;
        z_in_valid = 1'b0; z_flush = 1'b0; z_out_ready = 1'b0; z_instr = '0;
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_in_two();
        test_xlen64();
        test_skid0_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
